// File: rtl/dl11_pkg.sv
// rtl/dl11_pkg.sv - shared register map, bit positions and FSM state types for the DL11 unit
package dl11_pkg;

  localparam logic [2:0] OFF_RCSR = 3'd0;
  localparam logic [2:0] OFF_RBUF = 3'd2;
  localparam logic [2:0] OFF_XCSR = 3'd4;
  localparam logic [2:0] OFF_XBUF = 3'd6;

  localparam int RCSR_DONE  = 7;
  localparam int RCSR_IE    = 6;
  localparam int XCSR_READY = 7;
  localparam int XCSR_IE    = 6;
  localparam int XCSR_BREAK = 0;
  localparam int RBUF_ERR   = 15;
  localparam int RBUF_OR    = 14;
  localparam int RBUF_FE    = 13;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/dl11_channel.sv
// rtl/dl11_channel.sv - one DL11 line: 8N1 transmitter, receiver with FIFO, and its four registers
module dl11_channel
  import dl11_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int RX_DEPTH     = 4
) (
  input  logic        sys_clk,
  input  logic        RESET_n,
  input  logic        rxd,
  input  logic        wr_rcsr,
  input  logic        wr_xcsr,
  input  logic        wr_xbuf,
  input  logic        pop,
  input  logic [7:0]  wdata,
  input  logic [1:0]  reg_sel,
  output logic [15:0] rdata,
  output logic        txd,
  output logic        rx_irq,
  output logic        tx_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
  localparam logic [AW:0]   FULL    = (AW + 1)'(RX_DEPTH);

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    xbuf;
  logic          ready, tx_ie, brk, tx_line;
  logic          tx_tick, tx_load;

  assign tx_tick = (tx_cnt == BIT_END);
  assign tx_load = wr_xbuf & ready;

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) tx_state <= TX_IDLE;
    else          tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // xbuf doubles as the shift source: it cannot change while a frame is in flight
  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = xbuf[tx_idx];
      default:  tx_line = 1'b1;
    endcase
    txd = tx_line & ~brk;
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      xbuf   <= '0;
      ready  <= 1'b1;
      tx_ie  <= 1'b0;
      brk    <= 1'b0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 1'b1;
      if (tx_state == TX_DATA && tx_tick) tx_idx <= tx_idx + 1'b1;
      if (tx_load) begin
        xbuf  <= wdata;
        ready <= 1'b0;
      end else if (tx_state == TX_STOP && tx_tick) begin
        ready <= 1'b1;
      end
      if (wr_xcsr) begin
        tx_ie <= wdata[XCSR_IE];
        brk   <= wdata[XCSR_BREAK];
      end
    end
  end

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_s1, rx_s2, rx_s3, rx_tick, rx_push, rx_ie;

  assign rx_tick = (rx_cnt == ((rx_state == RX_START) ? HALF : BIT_END));

  // rx_s3 is only an edge-detect delay; the line is sampled from rx_s2
  always_ff @(posedge sys_clk) begin
    if (!RESET_n) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else          {rx_s1, rx_s2, rx_s3} <= {rxd, rx_s1, rx_s2};
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) rx_state <= RX_IDLE;
    else          rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s2 && rx_s3) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    if (rx_state == RX_STOP && rx_tick) rx_push = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_ie    <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_idx   <= rx_idx + 1'b1;
      end
      if (wr_rcsr) rx_ie <= wdata[RCSR_IE];
    end
  end

  logic [8:0]    mem [RX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          ovr, empty, full, pop_ok, push_ok;
  logic [8:0]    head;

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign pop_ok  = pop & ~empty;
  assign push_ok = rx_push & (~full | pop_ok);
  assign head    = mem[rp];

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wp] <= {~rx_s2, rx_shift};
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovr   <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop_ok)               ovr <= 1'b0;
      else if (rx_push && full) ovr <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case ({reg_sel, 1'b0})
      OFF_RCSR: begin
        rdata[RCSR_DONE] = ~empty;
        rdata[RCSR_IE]   = rx_ie;
      end
      OFF_RBUF: if (!empty) begin
        rdata[7:0]      = head[7:0];
        rdata[RBUF_FE]  = head[8];
        rdata[RBUF_OR]  = ovr;
        rdata[RBUF_ERR] = head[8] | ovr;
      end
      OFF_XCSR: begin
        rdata[XCSR_READY] = ready;
        rdata[XCSR_IE]    = tx_ie;
        rdata[XCSR_BREAK] = brk;
      end
      default: rdata[7:0] = xbuf;
    endcase
  end

  assign rx_irq = rx_ie & ~empty;
  assign tx_irq = tx_ie & ready;

endmodule

// File: rtl/dl11_multi.sv
// rtl/dl11_multi.sv - multi-channel DL11 console unit: address decode and read mux over the channels
module dl11_multi
  import dl11_pkg::*;
#(
  parameter int CLK_FRQ   = 27_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int CHANNELS  = 2,
  parameter int BASE_ADDR = 16'o177560,
  parameter int RX_DEPTH  = 4
) (
  input  logic                sys_clk,
  input  logic                RESET_n,
  input  logic [15:0]         bus_addr,
  input  logic [15:0]         bus_wdata,
  input  logic                bus_wr,
  input  logic                bus_byte,
  input  logic                bus_rd,
  output logic                bus_hit,
  output logic [15:0]         bus_rdata,
  input  logic [CHANNELS-1:0] rxd,
  output logic [CHANNELS-1:0] txd,
  output logic [CHANNELS-1:0] rx_irq,
  output logic [CHANNELS-1:0] tx_irq
);

  localparam int CLKS_PER_BIT = CLK_FRQ / BAUD_RATE;

  logic [CHANNELS-1:0] hit;
  logic [15:0]         ch_rdata [CHANNELS];
  logic [2:0]          off;
  logic                low_ok;
  logic                unused_hi;

  // every writable bit lives in a low byte, so a high-byte write touches nothing
  assign off       = {bus_addr[2:1], 1'b0};
  assign low_ok    = ~bus_byte | ~bus_addr[0];
  assign unused_hi = ^bus_wdata[15:8];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [15:0] CH_BASE = 16'(BASE_ADDR + 8 * k);
    assign hit[k] = (bus_addr[15:3] == CH_BASE[15:3]);

    dl11_channel #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .RX_DEPTH    (RX_DEPTH)
    ) u_ch (
      .sys_clk(sys_clk),
      .RESET_n(RESET_n),
      .rxd    (rxd[k]),
      .wr_rcsr(bus_wr & hit[k] & low_ok & (off == OFF_RCSR)),
      .wr_xcsr(bus_wr & hit[k] & low_ok & (off == OFF_XCSR)),
      .wr_xbuf(bus_wr & hit[k] & low_ok & (off == OFF_XBUF)),
      .pop    (bus_rd & hit[k] & (off == OFF_RBUF)),
      .wdata  (bus_wdata[7:0]),
      .reg_sel(bus_addr[2:1]),
      .rdata  (ch_rdata[k]),
      .txd    (txd[k]),
      .rx_irq (rx_irq[k]),
      .tx_irq (tx_irq[k])
    );
  end

  assign bus_hit = |hit;

  always_comb begin
    bus_rdata = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (hit[k]) bus_rdata = bus_rdata | ch_rdata[k];
    end
  end

endmodule

// File: tb/tb_dl11_multi.sv
// tb/tb_dl11_multi.sv - directed self-checking bench for dl11_multi
module tb_dl11_multi;

  localparam int CPB = 234;

  logic        sys_clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_wr = 1'b0;
  logic        bus_byte = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_hit;
  logic [15:0] bus_rdata;
  logic [1:0]  rxd = 2'b11;
  logic [1:0]  txd, rx_irq, tx_irq;
  logic [15:0] rd;
  int          checks = 0;
  int          failures = 0;

  always #5 sys_clk = ~sys_clk;

  dl11_multi #(
    .CLK_FRQ  (27_000_000),
    .BAUD_RATE(115200),
    .CHANNELS (2),
    .BASE_ADDR(16'o177560),
    .RX_DEPTH (4)
  ) dut (
    .sys_clk  (sys_clk),
    .RESET_n  (RESET_n),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wr   (bus_wr),
    .bus_byte (bus_byte),
    .bus_rd   (bus_rd),
    .bus_hit  (bus_hit),
    .bus_rdata(bus_rdata),
    .rxd      (rxd),
    .txd      (txd),
    .rx_irq   (rx_irq),
    .tx_irq   (tx_irq)
  );

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic b);
    @(negedge sys_clk);
    bus_addr = a; bus_wdata = d; bus_byte = b; bus_wr = 1'b1;
    @(negedge sys_clk);
    bus_wr = 1'b0; bus_byte = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge sys_clk);
    bus_addr = a;
    #1 d = bus_rdata;
  endtask

  task automatic bus_pop(input logic [15:0] a);
    @(negedge sys_clk);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge sys_clk);
    bus_rd = 1'b0;
  endtask

  task automatic send_byte(input int ch, input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd[ch] = f[b];
      repeat (CPB) @(negedge sys_clk);
    end
    rxd[ch] = 1'b1;
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic test_reset;
    RESET_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    RESET_n = 1'b1;
    @(negedge sys_clk);
    bus_read(16'o177560, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL reset_rcsr0 got %o expected %o", rd, 16'o000000); end
    bus_read(16'o177564, rd);
    checks++; if (rd !== 16'o000200) begin failures++; $display("FAIL reset_xcsr0 got %o expected %o", rd, 16'o000200); end
    checks++; if (bus_hit !== 1'b1) begin failures++; $display("FAIL hit_xcsr0 got %b expected 1", bus_hit); end
    checks++; if (txd !== 2'b11) begin failures++; $display("FAIL reset_txd got %b expected 11", txd); end
    checks++; if ({rx_irq, tx_irq} !== 4'b0000) begin failures++; $display("FAIL reset_irq got %b expected 0000", {rx_irq, tx_irq}); end
    bus_read(16'o177576, rd);
    checks++; if (bus_hit !== 1'b1 || rd !== 16'h0000) begin failures++; $display("FAIL hit_last got hit=%b data=%h expected hit=1 data=0000", bus_hit, rd); end
    bus_read(16'o177600, rd);
    checks++; if (bus_hit !== 1'b0 || rd !== 16'h0000) begin failures++; $display("FAIL miss_above got hit=%b data=%h expected hit=0 data=0000", bus_hit, rd); end
  endtask

  task automatic test_tx;
    logic [9:0] fr;
    fr = {1'b1, 8'h41, 1'b0};
    bus_write(16'o177566, 16'h0041, 1'b0);
    bus_write(16'o177566, 16'h0055, 1'b0);
    bus_addr = 16'o177564;
    repeat (115) @(negedge sys_clk);
    for (int b = 0; b < 10; b++) begin
      checks++; if (txd[0] !== fr[b]) begin failures++; $display("FAIL tx_bit%0d got %b expected %b", b, txd[0], fr[b]); end
      if (b < 9) repeat (CPB) @(negedge sys_clk);
    end
    repeat (116) @(negedge sys_clk);
    checks++; if (bus_rdata[7] !== 1'b0) begin failures++; $display("FAIL tx_ready_busy got %b expected 0", bus_rdata[7]); end
    @(negedge sys_clk);
    checks++; if (bus_rdata !== 16'o000200) begin failures++; $display("FAIL tx_ready_back got %o expected %o", bus_rdata, 16'o000200); end
    checks++; if (txd[0] !== 1'b1) begin failures++; $display("FAIL tx_idle got %b expected 1", txd[0]); end
    bus_read(16'o177566, rd);
    checks++; if (rd !== 16'h0041) begin failures++; $display("FAIL tx_xbuf got %h expected 0041", rd); end
  endtask

  task automatic test_rx;
    send_byte(1, 8'h5A, 1'b1);
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000200) begin failures++; $display("FAIL rx_done got %o expected %o", rd, 16'o000200); end
    bus_read(16'o177560, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL rx_other_ch got %o expected 0", rd); end
    bus_read(16'o177572, rd);
    checks++; if (rd !== 16'h005A) begin failures++; $display("FAIL rx_data got %h expected 005a", rd); end
    bus_pop(16'o177572);
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL rx_pop_done got %o expected 0", rd); end
    bus_read(16'o177572, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL rx_empty_read got %h expected 0000", rd); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) send_byte(1, 8'(8'h11 * (i + 1)), 1'b1);
    bus_read(16'o177572, rd);
    checks++; if (rd !== 16'hC011) begin failures++; $display("FAIL ovr_first got %h expected c011", rd); end
    bus_pop(16'o177572);
    bus_read(16'o177572, rd);
    checks++; if (rd !== 16'h0022) begin failures++; $display("FAIL ovr_second got %h expected 0022", rd); end
    repeat (3) bus_pop(16'o177572);
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL ovr_drained got %o expected 0", rd); end
  endtask

  task automatic test_framing;
    send_byte(1, 8'hA5, 1'b0);
    bus_read(16'o177572, rd);
    checks++; if (rd !== 16'hA0A5) begin failures++; $display("FAIL fe_rbuf got %h expected a0a5", rd); end
    bus_pop(16'o177572);
  endtask

  task automatic test_glitch;
    @(negedge sys_clk);
    rxd[1] = 1'b0;
    repeat (30) @(negedge sys_clk);
    rxd[1] = 1'b1;
    repeat (3 * CPB) @(negedge sys_clk);
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL glitch_done got %o expected 0", rd); end
  endtask

  task automatic test_irq;
    bus_write(16'o177570, 16'o000100, 1'b0);
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000100) begin failures++; $display("FAIL rcsr_ie got %o expected %o", rd, 16'o000100); end
    checks++; if (rx_irq !== 2'b00) begin failures++; $display("FAIL rx_irq_idle got %b expected 00", rx_irq); end
    send_byte(1, 8'h3C, 1'b1);
    checks++; if (rx_irq !== 2'b10) begin failures++; $display("FAIL rx_irq_set got %b expected 10", rx_irq); end
    bus_pop(16'o177572);
    checks++; if (rx_irq !== 2'b00) begin failures++; $display("FAIL rx_irq_clr got %b expected 00", rx_irq); end
    bus_write(16'o177564, 16'o000100, 1'b0);
    checks++; if (tx_irq !== 2'b01) begin failures++; $display("FAIL tx_irq_set got %b expected 01", tx_irq); end
    bus_write(16'o177565, 16'hFF00, 1'b1);
    bus_read(16'o177564, rd);
    checks++; if (rd !== 16'o000300) begin failures++; $display("FAIL xcsr_hi_byte got %o expected %o", rd, 16'o000300); end
    bus_write(16'o177564, 16'o000101, 1'b0);
    checks++; if (txd[0] !== 1'b0) begin failures++; $display("FAIL break_txd got %b expected 0", txd[0]); end
    bus_read(16'o177564, rd);
    checks++; if (rd !== 16'o000301) begin failures++; $display("FAIL break_xcsr got %o expected %o", rd, 16'o000301); end
    bus_write(16'o177564, 16'o000000, 1'b0);
    checks++; if (txd !== 2'b11 || tx_irq !== 2'b00) begin failures++; $display("FAIL break_off got txd=%b tx_irq=%b expected 11/00", txd, tx_irq); end
  endtask

  task automatic test_reset_mid_tx;
    bus_write(16'o177566, 16'h1277, 1'b1);
    bus_read(16'o177564, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL byte_xbuf_busy got %o expected 0", rd); end
    bus_read(16'o177566, rd);
    checks++; if (rd !== 16'h0077) begin failures++; $display("FAIL byte_xbuf_val got %h expected 0077", rd); end
    repeat (1000) @(negedge sys_clk);
    checks++; if (txd[0] !== 1'b0) begin failures++; $display("FAIL mid_frame_zero got %b expected 0", txd[0]); end
    RESET_n = 1'b0;
    @(negedge sys_clk);
    checks++; if (txd[0] !== 1'b1) begin failures++; $display("FAIL reset_abort_txd got %b expected 1", txd[0]); end
    RESET_n = 1'b1;
    bus_read(16'o177564, rd);
    checks++; if (rd !== 16'o000200) begin failures++; $display("FAIL reset_abort_ready got %o expected %o", rd, 16'o000200); end
    bus_read(16'o177566, rd);
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL reset_abort_xbuf got %h expected 0000", rd); end
    bus_read(16'o177570, rd);
    checks++; if (rd !== 16'o000000) begin failures++; $display("FAIL reset_abort_rcsr1 got %o expected 0", rd); end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_overflow;
    test_framing;
    test_glitch;
    test_irq;
    test_reset_mid_tx;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
